// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
package seg_pkg;

    // Active-high segment patterns {g,f,e,d,c,b,a} for hex digits 0..F.
    localparam logic [6:0] SegLut [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Datapath-side inputs and display-pin outputs of the scan driver.
interface seg_scan_driver_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    import seg_pkg::*;

    localparam int unsigned IdxW = idx_width(NUM_DIGITS);

    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    lzs;
    logic                    load;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    dp_out;
    logic [IdxW-1:0]         digit_idx;
    logic                    frame_done;

    // Datapath / stimulus side.
    modport master (
        output value, dp, blank, lzs, load,
        input  an, seg, dp_out, digit_idx, frame_done
    );

    // Driver side.
    modport slave (
        input  value, dp, blank, lzs, load,
        output an, seg, dp_out, digit_idx, frame_done
    );

endinterface

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-high seven-segment decode.
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = SegLut[nib_i];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver with double-buffered display value,
// dead time between digits, blanking and leading-zero suppression.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned PRESCALE   = 50000,
    parameter int unsigned DEAD       = 2,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    seg_scan_driver_if.slave bus
);

    localparam int unsigned IdxW = idx_width(NUM_DIGITS);
    localparam int unsigned PcW  = idx_width(PRESCALE);

    localparam logic [IdxW-1:0]       LastIdx = IdxW'(NUM_DIGITS - 1);
    localparam logic [PcW-1:0]        LastPc  = PcW'(PRESCALE - 1);
    localparam logic [NUM_DIGITS-1:0] AnOff   = ACTIVE_LOW ? '1 : '0;
    localparam logic [6:0]            SegOff  = ACTIVE_LOW ? '1 : '0;
    localparam logic                  DpOff   = ACTIVE_LOW;

    logic [PcW-1:0]          pc_q, pc_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    seen_q, seen_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_out_q, dp_out_d;
    logic                    frame_done_q, frame_done_d;

    logic                    slot_end;
    logic                    frame_end;
    logic                    in_dead;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic                    cur_zero;
    logic                    zeros_above;
    logic                    dark;
    logic [6:0]              dec_seg;
    logic [NUM_DIGITS-1:0]   an_onehot;
    logic [NUM_DIGITS-1:0]   an_hi;
    logic [6:0]              seg_hi;
    logic                    dp_hi;

    // Prescaler and digit counter; frame_done registered to line up with the last cycle.
    always_comb begin
        slot_end  = (pc_q == LastPc);
        frame_end = slot_end && (idx_q == LastIdx);
        pc_d      = slot_end ? '0 : pc_q + 1'b1;
        idx_d     = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
        end
        frame_done_d = (pc_d == LastPc) && (idx_d == LastIdx);
    end

    // Pending/display double buffer; a load on the boundary bypasses pending.
    always_comb begin
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        seen_d     = seen_q;
        if (bus.load) begin
            pend_val_d = bus.value;
            pend_dp_d  = bus.dp;
        end
        if (frame_end) begin
            seen_d = 1'b0;
            if (bus.load) begin
                disp_val_d = bus.value;
                disp_dp_d  = bus.dp;
            end else if (seen_q) begin
                disp_val_d = pend_val_q;
                disp_dp_d  = pend_dp_q;
            end
        end else if (bus.load) begin
            seen_d = 1'b1;
        end
    end

    // Select the current digit's nibble, dp and blank; track "all nibbles from here up are zero".
    always_comb begin
        cur_nib     = '0;
        cur_dp      = 1'b0;
        cur_blank   = 1'b0;
        cur_zero    = 1'b0;
        zeros_above = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            zeros_above = zeros_above & (disp_val_q[4*i +: 4] == 4'h0);
            if (idx_q == IdxW'(i)) begin
                cur_nib   = disp_val_q[4*i +: 4];
                cur_dp    = disp_dp_q[i];
                cur_blank = bus.blank[i];
                cur_zero  = zeros_above;
            end
        end
    end

    hex7seg u_hex7seg (
        .nib_i (cur_nib),
        .seg_o (dec_seg)
    );

    if (DEAD == 0) begin : g_no_dead
        assign in_dead = 1'b0;
    end else begin : g_dead
        assign in_dead = (pc_q < PcW'(DEAD));
    end

    assign an_onehot = NUM_DIGITS'(1) << idx_q;

    // Pin values for the current state; polarity applied before the output register.
    always_comb begin
        dark     = cur_blank | (bus.lzs & (idx_q != '0) & cur_zero);
        an_hi    = in_dead ? '0 : an_onehot;
        seg_hi   = (in_dead || dark) ? '0 : dec_seg;
        dp_hi    = (in_dead || dark) ? 1'b0 : cur_dp;
        an_d     = ACTIVE_LOW ? ~an_hi : an_hi;
        seg_d    = ACTIVE_LOW ? ~seg_hi : seg_hi;
        dp_out_d = ACTIVE_LOW ? ~dp_hi : dp_hi;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= '0;
            idx_q        <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            seen_q       <= 1'b0;
            an_q         <= AnOff;
            seg_q        <= SegOff;
            dp_out_q     <= DpOff;
            frame_done_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            idx_q        <= idx_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            seen_q       <= seen_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_out_q     <= dp_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp_out     = dp_out_q;
    assign bus.digit_idx  = idx_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (4 digits, prescale 8, dead 2, active-low).
module tb_seg_scan_driver;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    seg_scan_driver_if #(.NUM_DIGITS(4)) bus ();

    seg_scan_driver #(
        .NUM_DIGITS (4),
        .PRESCALE   (8),
        .DEAD       (2),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc = number of non-reset edges since the last reset edge = current pc position.
    task automatic step();
        @(posedge clk);
        #1;
        if (rst) cyc = 0;
        else cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance until the pins show state (slot d, pc p), i.e. the previous cycle was there.
    task automatic wait_state(input int d, input int p);
        bit found = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (((cyc - 1) % 8 == p) && (((cyc - 1) / 8) % 4 == d)) begin
                found = 1'b1;
                break;
            end
            step();
        end
        checks++;
        assert (found) else begin
            errors++;
            $error("FAIL wait_state observed=timeout expected=slot%0d_pc%0d", d, p);
        end
    endtask

    task automatic wait_frame_done();
        for (int n = 0; n < 40; n++) begin
            if (bus.frame_done === 1'b1) break;
            step();
        end
        check("frame_done_seen", 32'(bus.frame_done), 1);
    endtask

    task automatic check_pins(input string tag, input logic [3:0] an,
                              input logic [6:0] seg, input logic dp);
        check({tag, "_an"}, 32'(bus.an), 32'(an));
        check({tag, "_seg"}, 32'(bus.seg), 32'(seg));
        check({tag, "_dp"}, 32'(bus.dp_out), 32'(dp));
    endtask

    initial begin
        logic [3:0] e_an;
        int         p;
        int         d;
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        rst        = 1'b1;
        bus.value  = '0;
        bus.dp     = '0;
        bus.blank  = '0;
        bus.lzs    = 1'b0;
        bus.load   = 1'b0;

        // Reset held three cycles.
        step(); step(); step();
        rst = 1'b0;
        check_pins("reset", 4'b1111, 7'b1111111, 1'b1);
        check("reset_idx", 32'(bus.digit_idx), 0);
        check("reset_fd", 32'(bus.frame_done), 0);

        // Two full frames of scanning with value 0000.
        for (int k = 0; k < 64; k++) begin
            step();
            p    = (cyc - 1) % 8;
            d    = ((cyc - 1) / 8) % 4;
            e_an = (p < 2) ? 4'hF : ~(4'b0001 << d);
            check("scan_an", 32'(bus.an), 32'(e_an));
            check("scan_seg", 32'(bus.seg), (p < 2) ? 'b1111111 : 'b1000000);
            check("scan_fd", 32'(bus.frame_done), (cyc % 32 == 31) ? 1 : 0);
            check("scan_idx", 32'(bus.digit_idx), (cyc / 8) % 4);
        end

        // Mid-frame load stays hidden until the frame boundary.
        while (cyc < 70) step();
        bus.value = 16'h1234;
        bus.load  = 1'b1;
        step();
        bus.load  = 1'b0;
        wait_state(3, 4);
        check_pins("tear_d3_old", 4'b0111, 7'b1000000, 1'b1);
        wait_state(0, 4);
        check_pins("load_d0_4", 4'b1110, 7'b0011001, 1'b1);
        wait_state(3, 4);
        check_pins("load_d3_1", 4'b0111, 7'b1111001, 1'b1);

        // Two loads in one frame: only the last one appears.
        wait_state(0, 2);
        bus.value = 16'hAAAA;
        bus.load  = 1'b1;
        step();
        bus.load  = 1'b0;
        wait_state(1, 2);
        bus.value = 16'hBBBB;
        bus.load  = 1'b1;
        step();
        bus.load  = 1'b0;
        bus.value = 16'h5678;
        wait_state(2, 4);
        check_pins("dbl_d2_old", 4'b1011, 7'b0100100, 1'b1);
        wait_state(0, 4);
        check_pins("dbl_d0_b", 4'b1110, 7'b0000011, 1'b1);
        wait_state(3, 4);
        check_pins("dbl_d3_b", 4'b0111, 7'b0000011, 1'b1);

        // Load coincident with frame_done goes straight to the display.
        wait_frame_done();
        bus.value = 16'h00F0;
        bus.load  = 1'b1;
        step();
        bus.load  = 1'b0;
        check("bnd_fd_low", 32'(bus.frame_done), 0);
        wait_state(0, 4);
        check_pins("bnd_d0", 4'b1110, 7'b1000000, 1'b1);
        wait_state(1, 4);
        check_pins("bnd_d1_f", 4'b1101, 7'b0001110, 1'b1);

        // Leading-zero suppression, decimal point, then blanking.
        bus.value = 16'h0050;
        bus.dp    = 4'b0010;
        bus.lzs   = 1'b1;
        bus.load  = 1'b1;
        step();
        bus.load  = 1'b0;
        wait_frame_done();
        step();
        wait_state(0, 4);
        check_pins("lzs_d0", 4'b1110, 7'b1000000, 1'b1);
        wait_state(1, 0);
        check_pins("lzs_dead", 4'b1111, 7'b1111111, 1'b1);
        wait_state(1, 4);
        check_pins("lzs_d1", 4'b1101, 7'b0010010, 1'b0);
        wait_state(2, 4);
        check_pins("lzs_d2", 4'b1011, 7'b1111111, 1'b1);
        wait_state(3, 4);
        check_pins("lzs_d3", 4'b0111, 7'b1111111, 1'b1);
        bus.blank = 4'b0001;
        wait_state(0, 4);
        check_pins("blank_d0", 4'b1110, 7'b1111111, 1'b1);

        // Reset at pc=5 of slot 2 with a pending load outstanding.
        bus.blank = 4'b0000;
        bus.lzs   = 1'b0;
        wait_state(1, 0);
        bus.value = 16'h9999;
        bus.load  = 1'b1;
        step();
        bus.load  = 1'b0;
        wait_state(2, 4);
        check("pre_rst_idx", 32'(bus.digit_idx), 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_pins("mid_rst", 4'b1111, 7'b1111111, 1'b1);
        check("mid_rst_idx", 32'(bus.digit_idx), 0);
        check("mid_rst_fd", 32'(bus.frame_done), 0);
        wait_state(1, 4);
        check_pins("rst_d1_clr", 4'b1101, 7'b1000000, 1'b1);
        wait_state(0, 4);
        check_pins("rst_pend_drop", 4'b1110, 7'b1000000, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
